// File: rtl/data_mem_ctrl.sv
// Byte-addressed RISC-V data memory with request/response handshake,
// configurable latency, lane-correct sub-word access and fault reporting.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [3:0]  rmask,
  output logic [3:0]  wmask
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [2:0] CNT0 = 3'((LATENCY > 1) ? LATENCY - 2 : 0);

  logic [1:0]  state;
  logic [2:0]  cnt;
  logic        l_write;
  logic [2:0]  l_f3;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [31:0] mem [DEPTH_WORDS];

  logic        c_write;
  logic [2:0]  c_f3;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        commit;
  logic [1:0]  off;
  logic [29:0] word;
  logic [AW-1:0] idx;
  logic        in_range;
  logic        bad_f3;
  logic        misal;
  logic        fault;
  logic [3:0]  base;
  logic [3:0]  mask;
  logic [31:0] rword;
  logic [31:0] shifted;
  logic [31:0] ext;
  logic [31:0] wshift;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  // Commit-time request view: with single-cycle latency the commit edge
  // is the accept edge, so the live inputs are used instead of the latch.
  always_comb begin
    c_write = (state == IDLE) ? req_write  : l_write;
    c_f3    = (state == IDLE) ? req_funct3 : l_f3;
    c_addr  = (state == IDLE) ? req_addr   : l_addr;
    c_wdata = (state == IDLE) ? req_wdata  : l_wdata;
    commit  = ((state == IDLE) && req_valid && (LATENCY == 1)) ||
              ((state == WAIT) && (cnt == 3'd0));
  end

  // Decode: fault, lane mask, load extraction and store lane shift.
  always_comb begin
    off      = c_addr[1:0];
    word     = c_addr[31:2];
    idx      = word[AW-1:0];
    in_range = (word < 30'(DEPTH_WORDS));
    bad_f3   = c_write ? (c_f3 >= 3'd3)
                       : ((c_f3[1:0] == 2'b11) || (c_f3 == 3'b110));
    misal    = ((c_f3[1:0] == 2'b01) && off[0]) ||
               ((c_f3[1:0] == 2'b10) && (off != 2'b00));
    fault    = bad_f3 | misal | ~in_range;
    case (c_f3[1:0])
      2'b00:   base = 4'b0001;
      2'b01:   base = 4'b0011;
      default: base = 4'b1111;
    endcase
    mask    = base << off;
    rword   = mem[idx];
    shifted = rword >> {off, 3'b000};
    case (c_f3[1:0])
      2'b00:   ext = c_f3[2] ? {24'b0, shifted[7:0]}
                             : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ext = c_f3[2] ? {16'b0, shifted[15:0]}
                             : {{16{shifted[15]}}, shifted[15:0]};
      default: ext = shifted;
    endcase
    wshift = c_wdata << {off, 3'b000};
  end

  // Handshake FSM, request latch and registered response fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      l_write    <= 1'b0;
      l_f3       <= 3'd0;
      l_addr     <= 32'd0;
      l_wdata    <= 32'd0;
      resp_rdata <= 32'd0;
      resp_fault <= 1'b0;
      rmask      <= 4'd0;
      wmask      <= 4'd0;
    end else begin
      if (commit) begin
        resp_fault <= fault;
        resp_rdata <= (fault || c_write) ? 32'd0 : ext;
        rmask      <= (fault || c_write) ? 4'd0 : mask;
        wmask      <= (fault || !c_write) ? 4'd0 : mask;
      end
      case (state)
        IDLE: begin
          if (req_valid) begin
            l_write <= req_write;
            l_f3    <= req_funct3;
            l_addr  <= req_addr;
            l_wdata <= req_wdata;
            cnt     <= CNT0;
            state   <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 3'd0) state <= RESP;
          else cnt <= cnt - 3'd1;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array write on the commit edge; only enabled lanes change.
  always_ff @(posedge clk) begin
    if (commit && c_write && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) mem[idx][8*i +: 8] <= wshift[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one LATENCY=1 and one LATENCY=4
// instance, expected values hand-computed.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        v1, v4, rr1, rr4;
  logic        rdy1, rdy4, rv1, rv4, f1, f4;
  logic [31:0] rd1, rd4;
  logic [3:0]  rm1, rm4, wm1, wm4;
  logic        sel;
  int          errors = 0;
  int          checks = 0;

  logic        rdy, rv, flt;
  logic [31:0] rd;
  logic [3:0]  rm, wm;

  assign rdy = sel ? rdy4 : rdy1;
  assign rv  = sel ? rv4  : rv1;
  assign flt = sel ? f4   : f1;
  assign rd  = sel ? rd4  : rd1;
  assign rm  = sel ? rm4  : rm1;
  assign wm  = sel ? wm4  : wm1;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_WORDS(64), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst),
    .req_valid(v1), .req_ready(rdy1),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_ready(rr1),
    .resp_rdata(rd1), .resp_fault(f1),
    .rmask(rm1), .wmask(wm1)
  );

  data_mem_ctrl #(.DEPTH_WORDS(64), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst),
    .req_valid(v4), .req_ready(rdy4),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv4), .resp_ready(rr4),
    .resp_rdata(rd4), .resp_fault(f4),
    .rmask(rm4), .wmask(wm4)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xact(input string nm, input logic w, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] d,
                      input int stall, input logic [31:0] erd,
                      input logic ef, input logic [3:0] erm,
                      input logic [3:0] ewm);
    int n;
    @(negedge clk);
    check({nm, ":req_ready"}, 32'(rdy), 32'd1);
    req_write  = w;
    req_funct3 = f;
    req_addr   = a;
    req_wdata  = d;
    if (sel) v4 = 1'b1; else v1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    v4 = 1'b0;
    n = 0;
    while (!rv && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, ":latency"}, 32'(n), sel ? 32'd3 : 32'd0);
    for (int i = 0; i <= stall; i++) begin
      if (i > 0) @(negedge clk);
      check({nm, ":resp_valid"}, 32'(rv), 32'd1);
      check({nm, ":rdata"}, rd, erd);
      check({nm, ":fault"}, 32'(flt), 32'(ef));
      check({nm, ":rmask"}, 32'(rm), 32'(erm));
      check({nm, ":wmask"}, 32'(wm), 32'(ewm));
      check({nm, ":ready_busy"}, 32'(rdy), 32'd0);
    end
    if (sel) rr4 = 1'b1; else rr1 = 1'b1;
    @(negedge clk);
    rr1 = 1'b0;
    rr4 = 1'b0;
    check({nm, ":resp_done"}, 32'(rv), 32'd0);
    check({nm, ":ready_back"}, 32'(rdy), 32'd1);
  endtask

  task automatic check_reset(input string nm);
    check({nm, ":rst_ready"}, 32'(rdy), 32'd1);
    check({nm, ":rst_valid"}, 32'(rv), 32'd0);
    check({nm, ":rst_rdata"}, rd, 32'd0);
    check({nm, ":rst_fault"}, 32'(flt), 32'd0);
    check({nm, ":rst_rmask"}, 32'(rm), 32'd0);
    check({nm, ":rst_wmask"}, 32'(wm), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    v1 = 1'b0; v4 = 1'b0; rr1 = 1'b0; rr4 = 1'b0;
    req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    sel = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("l1");
    sel = 1'b1;
    #1;
    check_reset("l4");
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    xact("sw",   1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0, 4'h0, 4'hF);
    xact("lw",   0, 3'd2, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0, 4'hF, 4'h0);
    xact("lb",   0, 3'd0, 32'h13, 32'h0, 0, 32'hFFFFFFDE, 0, 4'h8, 4'h0);
    xact("lbu",  0, 3'd4, 32'h13, 32'h0, 0, 32'h000000DE, 0, 4'h8, 4'h0);
    xact("lh",   0, 3'd1, 32'h12, 32'h0, 0, 32'hFFFFDEAD, 0, 4'hC, 4'h0);
    xact("lhu",  0, 3'd5, 32'h10, 32'h0, 0, 32'h0000BEEF, 0, 4'h3, 4'h0);
    xact("f_lw", 0, 3'd2, 32'h12, 32'h0, 0, 32'h0, 1, 4'h0, 4'h0);
    xact("f_sh", 1, 3'd1, 32'h13, 32'h1111, 0, 32'h0, 1, 4'h0, 4'h0);
    xact("f_oor", 0, 3'd2, 32'h100, 32'h0, 0, 32'h0, 1, 4'h0, 4'h0);
    xact("f_f3", 0, 3'd3, 32'h10, 32'h0, 0, 32'h0, 1, 4'h0, 4'h0);
    xact("lw2",  0, 3'd2, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0, 4'hF, 4'h0);
    xact("sb",   1, 3'd0, 32'h11, 32'h55, 0, 32'h0, 0, 4'h0, 4'h2);
    xact("lw3",  0, 3'd2, 32'h10, 32'h0, 0, 32'hDEAD55EF, 0, 4'hF, 4'h0);

    sel = 1'b1;
    xact("l4_sw", 1, 3'd2, 32'h20, 32'hCAFEF00D, 0, 32'h0, 0, 4'h0, 4'hF);
    xact("l4_stall", 0, 3'd2, 32'h20, 32'h0, 5, 32'hCAFEF00D, 0, 4'hF, 4'h0);

    @(negedge clk);
    check("rst_wait:req_ready", 32'(rdy), 32'd1);
    req_write  = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h20;
    req_wdata  = 32'h12345678;
    v4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    xact("l4_after", 0, 3'd2, 32'h20, 32'h0, 0, 32'hCAFEF00D, 0, 4'hF, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
